// File: rtl/spec_level_ctrl.sv
// Speculation-level controller: ordered stack of unresolved predicted branches driving the br_pred_* broadcast.
// Optional feature macro SPEC_LEVEL_STATS_EN adds saturating succ/fail broadcast counters.
module spec_level_ctrl #(
  parameter int SPEC_DEPTH     = 4,
  parameter int INST_ID_BIT    = 8,
  parameter int SPEC_LEVEL_BIT = $clog2(SPEC_DEPTH) + 1,
  parameter int CNT_BIT        = 16
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      br_alloc_vld,
  output logic                                      br_alloc_rdy,
  input  logic [INST_ID_BIT-1:0]                    br_alloc_id,
  output logic [SPEC_LEVEL_BIT-1:0]                 cur_spec_level,
  output logic                                      dispatch_hold,
  input  logic                                      res_vld,
  output logic                                      res_rdy,
  input  logic [INST_ID_BIT-1:0]                    res_id,
  input  logic                                      res_succ,
  output logic                                      res_err,
  output logic                                      br_pred_vld,
  input  logic                                      br_pred_rdy,
  output logic                                      br_pred_succ,
  output logic [SPEC_LEVEL_BIT-1:0]                 br_pred_fail_level,
`ifdef SPEC_LEVEL_STATS_EN
  output logic [SPEC_LEVEL_BIT*(SPEC_DEPTH+1)-1:0]  br_pred_succ_nxt_levels,
  output logic [CNT_BIT-1:0]                        stat_succ_cnt,
  output logic [CNT_BIT-1:0]                        stat_fail_cnt
`else
  output logic [SPEC_LEVEL_BIT*(SPEC_DEPTH+1)-1:0]  br_pred_succ_nxt_levels
`endif
);

  localparam int LW = SPEC_LEVEL_BIT;
  localparam logic [LW-1:0] DEPTH_L = LW'(SPEC_DEPTH);

  if (SPEC_DEPTH < 1 || CNT_BIT < 1) begin : g_bad_params
    $error("spec_level_ctrl: SPEC_DEPTH and CNT_BIT must be >= 1");
  end

  logic [INST_ID_BIT-1:0] stk     [SPEC_DEPTH];
  logic [INST_ID_BIT-1:0] stk_nxt [SPEC_DEPTH];
  logic [LW-1:0]          cnt;
  logic [LW-1:0]          post_cnt;
  logic [LW-1:0]          hit_pos;
  logic                   hit;
  logic                   res_fire;
  logic                   succ_fire;
  logic                   fail_fire;
  logic                   alloc_fire;

  // Tag CAM over the valid part of the stack; lowest position wins on duplicates.
  always_comb begin
    hit     = 1'b0;
    hit_pos = '0;
    for (int unsigned i = 0; i < SPEC_DEPTH; i++) begin
      if (!hit && (LW'(i) < cnt) && (stk[i] == res_id)) begin
        hit     = 1'b1;
        hit_pos = LW'(i);
      end
    end
  end

  assign res_rdy   = br_pred_rdy;
  assign res_fire  = res_vld && br_pred_rdy;
  assign succ_fire = res_fire && hit && res_succ;
  assign fail_fire = res_fire && hit && !res_succ;

  always_comb begin
    post_cnt = cnt;
    if (succ_fire)
      post_cnt = cnt - LW'(1);
    else if (fail_fire)
      post_cnt = hit_pos;
  end

  assign cur_spec_level = post_cnt;
  assign dispatch_hold  = fail_fire;
  assign br_alloc_rdy   = (post_cnt < DEPTH_L) && !fail_fire;
  assign alloc_fire     = br_alloc_vld && br_alloc_rdy;

  assign br_pred_vld        = res_vld && hit;
  assign br_pred_succ       = res_succ;
  assign br_pred_fail_level = br_pred_vld ? hit_pos + LW'(1) : '0;

  // Levels above the resolved branch collapse down by one; lower levels are untouched.
  always_comb begin
    br_pred_succ_nxt_levels = '0;
    if (br_pred_vld) begin
      for (int unsigned l = 0; l <= SPEC_DEPTH; l++) begin
        if (LW'(l) > hit_pos)
          br_pred_succ_nxt_levels[l*LW +: LW] = LW'(l) - LW'(1);
        else
          br_pred_succ_nxt_levels[l*LW +: LW] = LW'(l);
      end
    end
  end

  // Resolution is applied first (shift-out on succ), then the push lands at the post-resolution top.
  always_comb begin
    stk_nxt = stk;
    for (int unsigned i = 0; i + 1 < SPEC_DEPTH; i++) begin
      if (succ_fire && (LW'(i) >= hit_pos))
        stk_nxt[i] = stk[i+1];
    end
    for (int unsigned i = 0; i < SPEC_DEPTH; i++) begin
      if (alloc_fire && (LW'(i) == post_cnt))
        stk_nxt[i] = br_alloc_id;
    end
  end

  always_ff @(posedge clk) begin
    stk <= stk_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      res_err <= 1'b0;
    end else begin
      cnt     <= alloc_fire ? post_cnt + LW'(1) : post_cnt;
      res_err <= res_fire && !hit;
    end
  end

`ifdef SPEC_LEVEL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_succ_cnt <= '0;
      stat_fail_cnt <= '0;
    end else if (br_pred_vld && br_pred_rdy) begin
      if (res_succ) begin
        if (stat_succ_cnt != '1)
          stat_succ_cnt <= stat_succ_cnt + CNT_BIT'(1);
      end else begin
        if (stat_fail_cnt != '1)
          stat_fail_cnt <= stat_fail_cnt + CNT_BIT'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_spec_level_ctrl.sv
// Self-checking bench for spec_level_ctrl: queue-based reference model checked every cycle plus directed literals.
module tb_spec_level_ctrl;

  localparam int D  = 4;
  localparam int IW = 8;
  localparam int LW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            br_alloc_vld;
  logic            br_alloc_rdy;
  logic [IW-1:0]   br_alloc_id;
  logic [LW-1:0]   cur_spec_level;
  logic            dispatch_hold;
  logic            res_vld;
  logic            res_rdy;
  logic [IW-1:0]   res_id;
  logic            res_succ;
  logic            res_err;
  logic            br_pred_vld;
  logic            br_pred_rdy;
  logic            br_pred_succ;
  logic [LW-1:0]   br_pred_fail_level;
  logic [LW*(D+1)-1:0] br_pred_succ_nxt_levels;

  spec_level_ctrl #(
    .SPEC_DEPTH(D),
    .INST_ID_BIT(IW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .br_alloc_vld(br_alloc_vld),
    .br_alloc_rdy(br_alloc_rdy),
    .br_alloc_id(br_alloc_id),
    .cur_spec_level(cur_spec_level),
    .dispatch_hold(dispatch_hold),
    .res_vld(res_vld),
    .res_rdy(res_rdy),
    .res_id(res_id),
    .res_succ(res_succ),
    .res_err(res_err),
    .br_pred_vld(br_pred_vld),
    .br_pred_rdy(br_pred_rdy),
    .br_pred_succ(br_pred_succ),
    .br_pred_fail_level(br_pred_fail_level),
    .br_pred_succ_nxt_levels(br_pred_succ_nxt_levels)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the outstanding branches as a plain ordered list, oldest first.
  logic [IW-1:0] q[$];
  logic          err_exp = 1'b0;

  always @(negedge clk) begin : compare
    int p;
    int post;
    bit hit;
    bit fire;
    bit hold;
    bit ardy;
    logic [LW*(D+1)-1:0] tbl;
    if (!rst_n) begin
      q.delete();
      err_exp = 1'b0;
    end
    p = -1;
    for (int i = 0; i < q.size(); i++)
      if (p < 0 && q[i] == res_id) p = i;
    hit  = (p >= 0);
    fire = res_vld && br_pred_rdy;
    post = q.size();
    if (fire && hit) post = res_succ ? q.size() - 1 : p;
    hold = fire && hit && !res_succ;
    ardy = (post < D) && !hold;
    tbl  = '0;
    if (res_vld && hit)
      for (int l = 0; l <= D; l++) tbl[l*LW +: LW] = LW'((l >= p + 1) ? l - 1 : l);

    chk("res_rdy", 32'(res_rdy), 32'(br_pred_rdy));
    chk("cur_spec_level", 32'(cur_spec_level), 32'(post));
    chk("dispatch_hold", 32'(dispatch_hold), 32'(hold));
    chk("br_alloc_rdy", 32'(br_alloc_rdy), 32'(ardy));
    chk("br_pred_vld", 32'(br_pred_vld), 32'(res_vld && hit));
    chk("res_err", 32'(res_err), 32'(err_exp));
    chk("nxt_levels", 32'(br_pred_succ_nxt_levels), 32'(tbl));
    if (res_vld && hit) begin
      chk("br_pred_succ", 32'(br_pred_succ), 32'(res_succ));
      chk("fail_level", 32'(br_pred_fail_level), 32'(p + 1));
    end

    if (rst_n) begin
      err_exp = fire && !hit;
      if (fire && hit) begin
        if (res_succ) q.delete(p);
        else while (q.size() > p) void'(q.pop_back());
      end
      if (br_alloc_vld && ardy) q.push_back(br_alloc_id);
    end
  end

  task automatic drive(input logic av, input logic [IW-1:0] aid, input logic rv,
                       input logic [IW-1:0] rid, input logic rs, input logic rdy);
    @(posedge clk); #1;
    br_alloc_vld = av;
    br_alloc_id  = aid;
    res_vld      = rv;
    res_id       = rid;
    res_succ     = rs;
    br_pred_rdy  = rdy;
    @(negedge clk); #1;
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  function automatic bit in_q(input logic [IW-1:0] id);
    for (int i = 0; i < q.size(); i++) if (q[i] == id) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    logic          av, rv, rs, rdy;
    logic [IW-1:0] aid, rid;
    rst_n = 1'b0;
    br_alloc_vld = 1'b0; br_alloc_id = '0;
    res_vld = 1'b0; res_id = '0; res_succ = 1'b0; br_pred_rdy = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst cur_spec_level", 32'(cur_spec_level), 32'd0);
    chk("rst br_alloc_rdy", 32'(br_alloc_rdy), 32'd1);
    chk("rst br_pred_vld", 32'(br_pred_vld), 32'd0);
    chk("rst dispatch_hold", 32'(dispatch_hold), 32'd0);
    chk("rst res_err", 32'(res_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fill to full, then try a fifth push.
    drive(1'b1, 8'h10, 1'b0, 8'h00, 1'b0, 1'b1); chk("push0 level", 32'(cur_spec_level), 32'd0);
    drive(1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 1'b1); chk("push1 level", 32'(cur_spec_level), 32'd1);
    drive(1'b1, 8'h12, 1'b0, 8'h00, 1'b0, 1'b1); chk("push2 level", 32'(cur_spec_level), 32'd2);
    drive(1'b1, 8'h13, 1'b0, 8'h00, 1'b0, 1'b1); chk("push3 level", 32'(cur_spec_level), 32'd3);
    drive(1'b1, 8'h14, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("full level", 32'(cur_spec_level), 32'd4);
    chk("full alloc_rdy", 32'(br_alloc_rdy), 32'd0);
    idle(); chk("fifth rejected", 32'(cur_spec_level), 32'd4);

    // Fail of the top leaves [10,11,12].
    drive(1'b0, 8'h00, 1'b1, 8'h13, 1'b0, 1'b1);
    chk("fail13 level", 32'(br_pred_fail_level), 32'd4);
    chk("fail13 hold", 32'(dispatch_hold), 32'd1);

    // Succ of the middle entry.
    drive(1'b0, 8'h00, 1'b1, 8'h11, 1'b1, 1'b1);
    chk("succ11 vld", 32'(br_pred_vld), 32'd1);
    chk("succ11 succ", 32'(br_pred_succ), 32'd1);
    chk("succ11 nxt", 32'(br_pred_succ_nxt_levels), 32'h3448);
    idle(); chk("after succ11 level", 32'(cur_spec_level), 32'd2);

    // [10,12] -> fail 12 -> [10] -> push 11,12 -> [10,11,12]; then fail 11 with a push attempt.
    drive(1'b0, 8'h00, 1'b1, 8'h12, 1'b0, 1'b1); chk("fail12 level", 32'(br_pred_fail_level), 32'd2);
    drive(1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b1, 8'h12, 1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b1, 8'h30, 1'b1, 8'h11, 1'b0, 1'b1);
    chk("fail11 level", 32'(br_pred_fail_level), 32'd2);
    chk("fail11 hold", 32'(dispatch_hold), 32'd1);
    chk("fail11 alloc_rdy", 32'(br_alloc_rdy), 32'd0);
    idle(); chk("after fail11 level", 32'(cur_spec_level), 32'd1);

    // Miss: one-cycle error pulse, state kept.
    drive(1'b0, 8'h00, 1'b1, 8'h55, 1'b1, 1'b1);
    chk("miss vld", 32'(br_pred_vld), 32'd0);
    idle(); chk("miss err", 32'(res_err), 32'd1);
    idle(); chk("miss err clr", 32'(res_err), 32'd0);
    chk("miss level", 32'(cur_spec_level), 32'd1);

    // Backpressure: broadcast held, no consumption until rdy.
    drive(1'b0, 8'h00, 1'b1, 8'h10, 1'b1, 1'b0);
    chk("bp res_rdy", 32'(res_rdy), 32'd0);
    chk("bp vld", 32'(br_pred_vld), 32'd1);
    drive(1'b0, 8'h00, 1'b1, 8'h10, 1'b1, 1'b0);
    chk("bp level held", 32'(cur_spec_level), 32'd1);
    drive(1'b0, 8'h00, 1'b1, 8'h10, 1'b1, 1'b1);
    chk("bp release level", 32'(cur_spec_level), 32'd0);

    // Full stack: succ of oldest plus push in the same cycle.
    drive(1'b1, 8'h10, 1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b1, 8'h12, 1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b1, 8'h13, 1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b1, 8'h20, 1'b1, 8'h10, 1'b1, 1'b1);
    chk("succ+push level", 32'(cur_spec_level), 32'd3);
    chk("succ+push rdy", 32'(br_alloc_rdy), 32'd1);
    idle(); chk("succ+push cnt", 32'(cur_spec_level), 32'd4);
    drive(1'b0, 8'h00, 1'b1, 8'h20, 1'b0, 1'b0); chk("pos of 20", 32'(br_pred_fail_level), 32'd4);
    drive(1'b0, 8'h00, 1'b1, 8'h11, 1'b0, 1'b0); chk("pos of 11", 32'(br_pred_fail_level), 32'd1);

    // Asynchronous reset mid-operation.
    @(posedge clk); #3;
    res_vld = 1'b0; br_alloc_vld = 1'b0; br_pred_rdy = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("async rst level", 32'(cur_spec_level), 32'd0);
    chk("async rst vld", 32'(br_pred_vld), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Randomized traffic; resolutions mostly target live tags.
    for (int n = 0; n < 3000; n++) begin
      av  = ($urandom_range(0, 99) < 55);
      aid = 8'($urandom_range(0, 63));
      if (in_q(aid)) av = 1'b0;
      rv  = ($urandom_range(0, 99) < 50);
      rs  = ($urandom_range(0, 99) < 60);
      rdy = ($urandom_range(0, 99) < 75);
      if (q.size() > 0 && $urandom_range(0, 99) < 80)
        rid = q[$urandom_range(0, q.size() - 1)];
      else
        rid = 8'($urandom_range(0, 255));
      drive(av, aid, rv, rid, rs, rdy);
    end

    idle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
